// File: rtl/io_map_pkg.sv
// Shared memory-map constants and poll-master state encoding for the
// data-memory/I-O responder bus.
package io_map_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT  = 32'h0000_0080;
    localparam logic [31:0] LOG_BASE_DEFAULT = 32'h0000_0000;

    localparam logic [31:0] PORT0_OFS = 32'd0;
    localparam logic [31:0] PORT1_OFS = 32'd4;
    localparam logic [31:0] PORT2_OFS = 32'd8;

    typedef logic [3:0] poll_state_t;

    // Encoding is visible to any future bus arbiter; keep values stable.
    localparam poll_state_t StIdle = 4'd0;
    localparam poll_state_t StRd0  = 4'd1;
    localparam poll_state_t StRd1  = 4'd2;
    localparam poll_state_t StRd2  = 4'd3;
    localparam poll_state_t StWr0  = 4'd4;
    localparam poll_state_t StWr1  = 4'd5;
    localparam poll_state_t StWr2  = 4'd6;
    localparam poll_state_t StLog  = 4'd7;
    localparam poll_state_t StDone = 4'd8;

endpackage

// File: rtl/io_poll_alu.sv
// Add or subtract two 4-bit operands into a 32-bit two's-complement result.
module io_poll_alu (
    input  logic [3:0]  a_i,
    input  logic [3:0]  b_i,
    input  logic        sub_i,
    output logic [31:0] res_o
);

    logic [31:0] a_ext;
    logic [31:0] b_ext;

    assign a_ext = {28'b0, a_i};
    assign b_ext = {28'b0, b_i};
    assign res_o = sub_i ? (a_ext - b_ext) : (a_ext + b_ext);

endmodule

// File: rtl/io_poll_master.sv
// Bus initiator that reads the three input ports, writes operands and a result
// back to the output ports, and logs each result into a RAM ring buffer.
module io_poll_master
    import io_map_pkg::*;
#(
    parameter logic [31:0] IO_BASE   = IO_BASE_DEFAULT,
    parameter logic [31:0] LOG_BASE  = LOG_BASE_DEFAULT,
    parameter int unsigned LOG_DEPTH = 32
) (
    input  logic        clock,
    input  logic        clrn,
    input  logic        start,
    input  logic        run_continuous,
    output logic [31:0] addr,
    output logic [31:0] datain,
    output logic        we,
    input  logic [31:0] dataout,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [15:0] pass_count
);

    localparam int unsigned PtrW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

    poll_state_t     state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     datain_q, datain_d;
    logic            we_q, we_d;
    logic            done_q;
    logic [31:0]     result_q;
    logic [15:0]     pass_count_q;
    logic [PtrW-1:0] ptr_q;
    logic [3:0]      in0_q, in1_q;
    logic            mode_q;
    logic [31:0]     alu_res;
    logic [31:0]     log_addr;

    // Only the low nibble (and bit 0 for mode) of read data is meaningful.
    logic unused_dataout;
    assign unused_dataout = ^dataout[31:4];

    io_poll_alu u_alu (
        .a_i   (in0_q),
        .b_i   (in1_q),
        .sub_i (mode_q),
        .res_o (alu_res)
    );

    assign log_addr = LOG_BASE + {{(30 - PtrW){1'b0}}, ptr_q, 2'b00};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRd0;
            StRd0:   state_d = StRd1;
            StRd1:   state_d = StRd2;
            StRd2:   state_d = StWr0;
            StWr0:   state_d = StWr1;
            StWr1:   state_d = StWr2;
            StWr2:   state_d = StLog;
            StLog:   state_d = StDone;
            StDone:  state_d = run_continuous ? StRd0 : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Bus values are decoded from the next state so they register alongside it.
    always_comb begin
        addr_d   = '0;
        datain_d = '0;
        we_d     = 1'b0;
        case (state_d)
            StRd0: addr_d = IO_BASE + PORT0_OFS;
            StRd1: addr_d = IO_BASE + PORT1_OFS;
            StRd2: addr_d = IO_BASE + PORT2_OFS;
            StWr0: begin
                addr_d   = IO_BASE + PORT0_OFS;
                datain_d = {28'b0, in0_q};
                we_d     = 1'b1;
            end
            StWr1: begin
                addr_d   = IO_BASE + PORT1_OFS;
                datain_d = {28'b0, in1_q};
                we_d     = 1'b1;
            end
            StWr2: begin
                addr_d   = IO_BASE + PORT2_OFS;
                datain_d = alu_res;
                we_d     = 1'b1;
            end
            StLog: begin
                addr_d   = log_addr;
                datain_d = alu_res;
                we_d     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            datain_q     <= '0;
            we_q         <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            pass_count_q <= '0;
            ptr_q        <= '0;
            in0_q        <= '0;
            in1_q        <= '0;
            mode_q       <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            datain_q <= datain_d;
            we_q     <= we_d;
            done_q   <= (state_d == StDone);
            if (state_q == StRd0) in0_q <= dataout[3:0];
            if (state_q == StRd1) in1_q <= dataout[3:0];
            if (state_q == StRd2) mode_q <= dataout[0];
            if (state_q == StWr2) result_q <= alu_res;
            if (state_q == StLog) ptr_q <= ptr_q + 1'b1;
            if (state_d == StDone) pass_count_q <= pass_count_q + 16'd1;
        end
    end

    assign addr       = addr_q;
    assign datain     = datain_q;
    assign we         = we_q;
    assign done       = done_q;
    assign busy       = (state_q != StIdle);
    assign result     = result_q;
    assign pass_count = pass_count_q;

endmodule

// File: tb/tb_io_poll_master.sv
// Randomised scoreboard bench for io_poll_master with a behavioural responder.
module tb_io_poll_master;

    logic        clock;
    logic        clrn;
    logic        start;
    logic        run_continuous;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        we;
    logic [31:0] dataout;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [15:0] pass_count;

    io_poll_master dut (
        .clock          (clock),
        .clrn           (clrn),
        .start          (start),
        .run_continuous (run_continuous),
        .addr           (addr),
        .datain         (datain),
        .we             (we),
        .dataout        (dataout),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .pass_count     (pass_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Responder: input ports carry random junk in their upper bits.
    logic [31:0] in_port0, in_port1, in_port2, ram_junk;
    always_comb begin
        dataout = ram_junk;
        if (addr[7]) begin
            case (addr[3:2])
                2'd0:    dataout = in_port0;
                2'd1:    dataout = in_port1;
                2'd2:    dataout = in_port2;
                default: dataout = ram_junk;
            endcase
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
        logic        chk_data;
        logic        done;
        logic        cont;
        logic [31:0] res;
    } rec_t;

    rec_t        exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int unsigned m_ptr = 0;
    int unsigned m_count = 0;
    logic        chk_next = 1'b0;
    logic        exp_next = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_rec(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic cd, input logic dn, input logic c, input logic [31:0] r);
        rec_t x;
        x.addr = a; x.we = w; x.data = d; x.chk_data = cd;
        x.done = dn; x.cont = c; x.res = r;
        exp_q.push_back(x);
    endtask

    // Reference: one pass is three reads, three port writes, a log write, done.
    task automatic push_pass(input logic [3:0] a, input logic [3:0] b, input logic m,
                             input logic cont);
        logic [31:0] res;
        res = m ? (32'(a) - 32'(b)) : (32'(a) + 32'(b));
        push_rec(32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, res);
        push_rec(32'h84, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, res);
        push_rec(32'h88, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, res);
        push_rec(32'h80, 1'b1, 32'(a), 1'b1, 1'b0, 1'b0, res);
        push_rec(32'h84, 1'b1, 32'(b), 1'b1, 1'b0, 1'b0, res);
        push_rec(32'h88, 1'b1, res, 1'b1, 1'b0, 1'b0, res);
        push_rec(32'(4 * m_ptr), 1'b1, res, 1'b1, 1'b0, 1'b0, res);
        push_rec(32'h0, 1'b0, 32'h0, 1'b0, 1'b1, cont, res);
        m_ptr   = (m_ptr + 1) % 32;
        m_count = (m_count + 1) % 65536;
    endtask

    task automatic set_inputs(input logic [3:0] a, input logic [3:0] b, input logic m);
        logic [31:0] r0, r1, r2;
        r0 = $urandom(); r1 = $urandom(); r2 = $urandom();
        in_port0 = {r0[31:4], a};
        in_port1 = {r1[31:4], b};
        in_port2 = {r2[31:1], m};
    endtask

    task automatic pulse_start();
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
    endtask

    task automatic wait_done(input int n_done, input int budget);
        int seen = 0;
        for (int i = 0; i < budget && seen < n_done; i++) begin
            @(negedge clock);
            if (done) seen++;
        end
        check("done_timeout", 32'(seen), 32'(n_done));
    endtask

    task automatic model_reset();
        exp_q.delete();
        chk_next = 1'b0;
        m_ptr    = 0;
        m_count  = 0;
    endtask

    // Monitor: every busy cycle must match the next expected bus record.
    initial begin
        rec_t r;
        forever begin
            @(negedge clock);
            if (chk_next) begin
                check("busy_after_done", 32'(busy), 32'(exp_next));
                chk_next = 1'b0;
            end
            if (busy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_busy: busy=1 addr=%h with no pass expected, required busy=0",
                             addr);
                end else begin
                    r = exp_q.pop_front();
                    check("bus_addr", addr, r.addr);
                    check("bus_we", 32'(we), 32'(r.we));
                    check("bus_done", 32'(done), 32'(r.done));
                    if (r.chk_data) check("bus_datain", datain, r.data);
                    if (r.done) begin
                        check("result", result, r.res);
                        chk_next = 1'b1;
                        exp_next = r.cont;
                    end
                end
            end else begin
                check("idle_we", 32'(we), 32'h0);
                check("idle_done", 32'(done), 32'h0);
                check("idle_addr", addr, 32'h0);
            end
        end
    end

    initial begin
        logic [3:0] a, b;
        logic       m;
        clrn = 1'b0;
        start = 1'b0;
        run_continuous = 1'b0;
        ram_junk = $urandom();
        set_inputs(4'h0, 4'h0, 1'b0);
        repeat (2) @(negedge clock);
        check("rst_addr", addr, 32'h0);
        check("rst_datain", datain, 32'h0);
        check("rst_we", 32'(we), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_pass_count", 32'(pass_count), 32'h0);
        clrn = 1'b1;
        repeat (5) begin
            @(negedge clock);
            check("post_rst_busy", 32'(busy), 32'h0);
        end

        // Add pass.
        set_inputs(4'h3, 4'h5, 1'b0);
        push_pass(4'h3, 4'h5, 1'b0, 1'b0);
        pulse_start();
        wait_done(1, 20);
        check("add_result", result, 32'd8);
        @(negedge clock);
        check("add_pass_count", 32'(pass_count), 32'd1);

        // Subtract pass logs into slot 1.
        set_inputs(4'h3, 4'h5, 1'b1);
        push_pass(4'h3, 4'h5, 1'b1, 1'b0);
        pulse_start();
        wait_done(1, 20);
        check("sub_result", result, 32'hFFFF_FFFE);
        @(negedge clock);
        check("sub_pass_count", 32'(pass_count), 32'd2);

        // Random single passes.
        repeat (6) begin
            a = 4'($urandom_range(15, 0));
            b = 4'($urandom_range(15, 0));
            m = 1'($urandom_range(1, 0));
            set_inputs(a, b, m);
            push_pass(a, b, m, 1'b0);
            pulse_start();
            wait_done(1, 20);
            @(negedge clock);
            check("rand_pass_count", 32'(pass_count), 32'(m_count));
        end

        // Continuous run of 33 passes wraps the log pointer.
        @(negedge clock) clrn = 1'b0;
        model_reset();
        @(negedge clock) clrn = 1'b1;
        a = 4'($urandom_range(15, 0));
        b = 4'($urandom_range(15, 0));
        m = 1'($urandom_range(1, 0));
        set_inputs(a, b, m);
        run_continuous = 1'b1;
        for (int i = 1; i <= 33; i++) push_pass(a, b, m, (i < 33));
        pulse_start();
        wait_done(32, 32 * 8 + 20);
        @(negedge clock) run_continuous = 1'b0;
        wait_done(1, 20);
        @(negedge clock);
        check("cont_pass_count", 32'(pass_count), 32'd33);
        check("cont_idle", 32'(busy), 32'h0);

        // Start during WR1 is ignored.
        set_inputs(4'h9, 4'h2, 1'b0);
        push_pass(4'h9, 4'h2, 1'b0, 1'b0);
        pulse_start();
        repeat (4) @(negedge clock);
        start = 1'b1;
        @(negedge clock) start = 1'b0;
        wait_done(1, 20);
        repeat (10) @(negedge clock);
        check("ignore_pass_count", 32'(pass_count), 32'd34);

        // Dropping run_continuous mid-pass drains to IDLE.
        set_inputs(4'h1, 4'hE, 1'b1);
        push_pass(4'h1, 4'hE, 1'b1, 1'b0);
        run_continuous = 1'b1;
        pulse_start();
        @(negedge clock) run_continuous = 1'b0;
        wait_done(1, 20);
        repeat (10) @(negedge clock);
        check("drain_pass_count", 32'(pass_count), 32'd35);

        // Reset during LOG drops we without a clock edge.
        set_inputs(4'h7, 4'h7, 1'b0);
        push_pass(4'h7, 4'h7, 1'b0, 1'b0);
        pulse_start();
        repeat (6) @(negedge clock);
        check("log_we", 32'(we), 32'h1);
        #2 clrn = 1'b0;
        model_reset();
        #1;
        check("async_we", 32'(we), 32'h0);
        check("async_busy", 32'(busy), 32'h0);
        check("async_pass_count", 32'(pass_count), 32'h0);
        @(negedge clock) clrn = 1'b1;
        a = 4'($urandom_range(15, 0));
        b = 4'($urandom_range(15, 0));
        set_inputs(a, b, 1'b0);
        push_pass(a, b, 1'b0, 1'b0);
        pulse_start();
        wait_done(1, 20);
        @(negedge clock);
        check("restart_pass_count", 32'(pass_count), 32'd1);
        repeat (3) @(negedge clock);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
